// File: rtl/wave_gen_pkg.sv
// wave_gen_pkg: waveform mode encodings and default widths for the DDS waveform generator.
package wave_gen_pkg;
  localparam int PHASE_W_DEF = 24;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;
  localparam int DIV_W_DEF = 16;
  localparam logic [1:0] MODE_TRI = 2'b00;
  localparam logic [1:0] MODE_SAW = 2'b01;
  localparam logic [1:0] MODE_SQR = 2'b10;
  localparam logic [1:0] MODE_RSAW = 2'b11;
endpackage

// File: rtl/wave_gen_if.sv
// wave_gen_if: config, run-control and sample handshake bundle; WAVE_GEN_AMPL_EN adds cfg_ampl.
interface wave_gen_if import wave_gen_pkg::*; #(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W = DIV_W_DEF
);
  logic en;
  logic cfg_we;
  logic [PHASE_W-1:0] cfg_ftw;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_duty;
  logic [DIV_W-1:0] cfg_div;
`ifdef WAVE_GEN_AMPL_EN
  logic [7:0] cfg_ampl;
`endif
  logic [DATA_W-1:0] sample_data;
  logic sample_valid;
  logic sample_ready;
  logic overrun;
  logic phase_wrap;
  modport master (
`ifdef WAVE_GEN_AMPL_EN
    output cfg_ampl,
`endif
    output en, cfg_we, cfg_ftw, cfg_mode, cfg_duty, cfg_div, sample_ready,
    input sample_data, sample_valid, overrun, phase_wrap
  );
  modport slave (
`ifdef WAVE_GEN_AMPL_EN
    input cfg_ampl,
`endif
    input en, cfg_we, cfg_ftw, cfg_mode, cfg_duty, cfg_div, sample_ready,
    output sample_data, sample_valid, overrun, phase_wrap
  );
endinterface

// File: rtl/wave_phase_acc.sv
// wave_phase_acc: prescaler, phase accumulator, wrap pulse and glitch-free config commit.
// WAVE_GEN_AMPL_EN adds the amplitude field to the shadow/active set.
module wave_phase_acc import wave_gen_pkg::*; #(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               cfg_we_i,
  input  logic [PHASE_W-1:0] cfg_ftw_i,
  input  logic [1:0]         cfg_mode_i,
  input  logic [7:0]         cfg_duty_i,
`ifdef WAVE_GEN_AMPL_EN
  input  logic [7:0]         cfg_ampl_i,
  output logic [7:0]         ampl_o,
`endif
  input  logic [DIV_W-1:0]   cfg_div_i,
  output logic               tick_o,
  output logic [DATA_W:0]    addr_o,
  output logic [1:0]         mode_o,
  output logic [7:0]         duty_o,
  output logic               phase_wrap_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d, sum, sh_ftw_q, act_ftw_q;
  logic [1:0] sh_mode_q, act_mode_q;
  logic [7:0] sh_duty_q, act_duty_q;
  logic carry, tick, commit, pend_q, wrap_q;
`ifdef WAVE_GEN_AMPL_EN
  logic [7:0] sh_ampl_q, act_ampl_q;
  assign ampl_o = act_ampl_q;
`endif
  always_comb begin
    tick = en_i && (cnt_q == cfg_div_i);
    {carry, sum} = {1'b0, phase_q} + {1'b0, act_ftw_q};
    phase_d = tick ? sum : phase_q;
    cnt_d = !en_i ? cnt_q : tick ? '0 : cnt_q + 1'b1;
    commit = pend_q && ((tick && carry) || !en_i || act_ftw_q == '0);
  end
  // A commit consumes the old shadow; a simultaneous write re-arms pending with the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      phase_q <= '0;
      wrap_q <= 1'b0;
      pend_q <= 1'b0;
      {sh_ftw_q, sh_mode_q, sh_duty_q} <= '0;
      {act_ftw_q, act_mode_q, act_duty_q} <= '0;
`ifdef WAVE_GEN_AMPL_EN
      sh_ampl_q <= 8'hFF;
      act_ampl_q <= 8'hFF;
`endif
    end else begin
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      wrap_q <= tick && carry;
      pend_q <= cfg_we_i || (pend_q && !commit);
      if (commit) {act_ftw_q, act_mode_q, act_duty_q} <= {sh_ftw_q, sh_mode_q, sh_duty_q};
      if (cfg_we_i) {sh_ftw_q, sh_mode_q, sh_duty_q} <= {cfg_ftw_i, cfg_mode_i, cfg_duty_i};
`ifdef WAVE_GEN_AMPL_EN
      if (commit) act_ampl_q <= sh_ampl_q;
      if (cfg_we_i) sh_ampl_q <= cfg_ampl_i;
`endif
    end
  end
  assign tick_o = tick;
  assign addr_o = phase_d[PHASE_W-1 -: DATA_W+1];
  assign mode_o = act_mode_q;
  assign duty_o = act_duty_q;
  assign phase_wrap_o = wrap_q;
endmodule

// File: rtl/wave_gen.sv
// wave_gen: DDS waveform generator top - waveform synthesis mux and sample valid/ready handshake.
// WAVE_GEN_AMPL_EN adds an amplitude scaling stage (latency 2 instead of 1).
module wave_gen import wave_gen_pkg::*; #(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input logic       clk,
  input logic       rst,
  wave_gen_if.slave bus
);
  if (ADDR_W - 1 < DATA_W) $error("wave_gen: ADDR_W-1 must be >= DATA_W");
  logic tick, load, valid_q, ovr_q;
  logic [DATA_W:0] a;
  logic [1:0] mode;
  logic [7:0] duty;
  logic [DATA_W-1:0] raw, ld_data, data_q;
`ifdef WAVE_GEN_AMPL_EN
  logic [7:0] ampl, ampl_q;
  logic [DATA_W-1:0] raw_q;
  logic ld_q;
  logic [DATA_W+7:0] prod;
`endif
  wave_phase_acc #(.PHASE_W(PHASE_W), .DATA_W(DATA_W), .DIV_W(DIV_W)) u_acc (
    .clk(clk), .rst(rst), .en_i(bus.en), .cfg_we_i(bus.cfg_we), .cfg_ftw_i(bus.cfg_ftw),
    .cfg_mode_i(bus.cfg_mode), .cfg_duty_i(bus.cfg_duty),
`ifdef WAVE_GEN_AMPL_EN
    .cfg_ampl_i(bus.cfg_ampl), .ampl_o(ampl),
`endif
    .cfg_div_i(bus.cfg_div), .tick_o(tick), .addr_o(a), .mode_o(mode), .duty_o(duty),
    .phase_wrap_o(bus.phase_wrap)
  );
  // a holds the top DATA_W+1 phase bits: MSB selects the triangle half, the rest is the ramp.
  always_comb
    raw = mode == MODE_TRI ? (a[DATA_W] ? ~a[DATA_W-1:0] : a[DATA_W-1:0]) :
          mode == MODE_SAW ? a[DATA_W:1] :
          mode == MODE_SQR ? {DATA_W{a[DATA_W -: 8] < duty}} : ~a[DATA_W:1];
`ifdef WAVE_GEN_AMPL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q <= '0;
      ampl_q <= 8'hFF;
      ld_q <= 1'b0;
    end else begin
      raw_q <= raw;
      ampl_q <= ampl;
      ld_q <= tick;
    end
  end
  assign prod = {8'b0, raw_q} * {{DATA_W{1'b0}}, ampl_q};
  assign ld_data = prod[DATA_W+7:8];
  assign load = ld_q;
`else
  assign ld_data = raw;
  assign load = tick;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      if (load) data_q <= ld_data;
      valid_q <= load || (valid_q && !bus.sample_ready);
      ovr_q <= ovr_q || (load && valid_q && !bus.sample_ready);
    end
  end
  assign bus.sample_data = data_q;
  assign bus.sample_valid = valid_q;
  assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: directed + randomized checks of wave_gen against a cycle-level arithmetic reference.
module tb_wave_gen;
  import wave_gen_pkg::*;
  localparam int PW = 24, DW = 8, VW = 16;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0, n_fail = 0;
  int m_phase, m_cnt, m_data, sh_ftw, sh_mode, sh_duty, sh_ampl, a_ftw, a_mode, a_duty, a_ampl;
  int p_raw, p_ampl;
  bit m_pend, m_valid, m_ovr, m_wrap, p_ld;
  wave_gen_if #(.PHASE_W(PW), .DATA_W(DW), .DIV_W(VW)) bus ();
  wave_gen #(.PHASE_W(PW), .ADDR_W(12), .DATA_W(DW), .DIV_W(VW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic int wave(int ph, int mode, int duty);
    int a, f;
    a = ph >> 12;
    f = (a >> 3) & 255;
    if (mode == 0) return (a >= 2048) ? 255 - f : f;
    if (mode == 1) return a >> 4;
    if (mode == 2) return ((a >> 4) < duty) ? 255 : 0;
    return 255 - (a >> 4);
  endfunction
  task automatic model_reset();
    {m_phase, m_cnt, m_data, sh_ftw, sh_mode, sh_duty, a_ftw, a_mode, a_duty, p_raw} = '0;
    {m_pend, m_valid, m_ovr, m_wrap, p_ld} = '0;
    sh_ampl = 255;
    a_ampl = 255;
    p_ampl = 255;
  endtask
  task automatic model_step();
    bit tick, carry, commit, load;
    int s, np, raw, ld;
    tick = bus.en && (m_cnt == int'(bus.cfg_div));
    np = m_phase;
    carry = 0;
    if (tick) begin
      s = m_phase + a_ftw;
      carry = s >= (1 << 24);
      np = s % (1 << 24);
    end
    commit = m_pend && ((tick && carry) || !bus.en || a_ftw == 0);
    raw = wave(np, a_mode, a_duty);
`ifdef WAVE_GEN_AMPL_EN
    load = p_ld;
    ld = (p_raw * p_ampl) >> 8;
    p_ld = tick;
    p_raw = raw;
    p_ampl = a_ampl;
`else
    load = tick;
    ld = raw;
`endif
    if (load && m_valid && !bus.sample_ready) m_ovr = 1;
    m_valid = load || (m_valid && !bus.sample_ready);
    if (load) m_data = ld;
    m_wrap = tick && carry;
    m_phase = np;
    if (bus.en) m_cnt = tick ? 0 : (m_cnt + 1) % 65536;
    if (commit) begin
      a_ftw = sh_ftw; a_mode = sh_mode; a_duty = sh_duty; a_ampl = sh_ampl;
    end
    if (bus.cfg_we) begin
      sh_ftw = int'(bus.cfg_ftw); sh_mode = int'(bus.cfg_mode); sh_duty = int'(bus.cfg_duty);
`ifdef WAVE_GEN_AMPL_EN
      sh_ampl = int'(bus.cfg_ampl);
`endif
    end
    m_pend = bus.cfg_we || (m_pend && !commit);
  endtask
  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) model_reset(); else model_step();
    chk("sample_data", int'(bus.sample_data), m_data);
    chk("sample_valid", int'(bus.sample_valid), int'(m_valid));
    chk("overrun", int'(bus.overrun), int'(m_ovr));
    chk("phase_wrap", int'(bus.phase_wrap), int'(m_wrap));
  endtask
  task automatic run(int n);
    repeat (n) step();
  endtask
  task automatic cfg(int ftw, int mode, int duty, int ampl);
    bus.cfg_we = 1'b1;
    bus.cfg_ftw = PW'(ftw);
    bus.cfg_mode = 2'(mode);
    bus.cfg_duty = 8'(duty);
`ifdef WAVE_GEN_AMPL_EN
    bus.cfg_ampl = 8'(ampl);
`else
    if (ampl < 0) $display("unused amplitude %0d", ampl);
`endif
    step();
    bus.cfg_we = 1'b0;
  endtask
  task automatic do_reset(int div);
    rst = 1'b1;
    bus.cfg_div = VW'(div);
    run(2);
    rst = 1'b0;
  endtask
  task automatic rand_run(int n);
    for (int k = 0; k < n; k++) begin
      bus.en = $urandom_range(0, 9) != 0;
      bus.sample_ready = $urandom_range(0, 2) != 0;
      bus.cfg_we = $urandom_range(0, 39) == 0;
      bus.cfg_ftw = PW'($urandom & 32'h3FFFFF);
      bus.cfg_mode = 2'($urandom);
      bus.cfg_duty = 8'($urandom);
`ifdef WAVE_GEN_AMPL_EN
      bus.cfg_ampl = 8'($urandom);
`endif
      step();
    end
    bus.cfg_we = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.en = 1'b1;
    bus.cfg_we = 1'b0;
    bus.cfg_ftw = '0;
    bus.cfg_mode = MODE_TRI;
    bus.cfg_duty = '0;
    bus.cfg_div = '0;
    bus.sample_ready = 1'b1;
`ifdef WAVE_GEN_AMPL_EN
    bus.cfg_ampl = 8'hFF;
`endif
    do_reset(0);
    chk("reset_valid", int'(bus.sample_valid), 0);
    chk("reset_data", int'(bus.sample_data), 0);
    // SAW ramp, one LSB per tick, wrap every 256 ticks
    cfg(24'h010000, MODE_SAW, 0, 255);
    run(600);
    // triangle
    do_reset(0);
    cfg(24'h080000, MODE_TRI, 0, 255);
    run(100);
    // square, duty 0x40 then duty 0
    do_reset(0);
    cfg(24'h100000, MODE_SQR, 8'h40, 255);
    run(80);
    cfg(24'h100000, MODE_SQR, 0, 255);
    run(80);
    // ftw change mid-period; two writes before the wrap, last one wins
    do_reset(0);
    cfg(24'h040000, MODE_SAW, 0, 255);
    run(20);
    cfg(24'h020000, MODE_SAW, 0, 255);
    run(5);
    cfg(24'h0C0000, MODE_RSAW, 0, 255);
    run(120);
    // prescaler with ready low across ticks, then ready high
    do_reset(3);
    cfg(24'h010000, MODE_SAW, 0, 255);
    bus.sample_ready = 1'b0;
    run(20);
    chk("overrun_set", int'(bus.overrun), 1);
    bus.sample_ready = 1'b1;
    run(20);
    do_reset(3);
    cfg(24'h010000, MODE_SAW, 0, 255);
    run(40);
    // en low holds phase and pending sample
    bus.sample_ready = 1'b0;
    bus.en = 1'b0;
    run(10);
    bus.en = 1'b1;
    bus.sample_ready = 1'b1;
    run(10);
    // randomized segments at several prescaler settings
    for (int d = 0; d < 4; d++) begin
      do_reset(d);
      rand_run(700);
    end
    // reset mid-stream with valid high
    bus.en = 1'b1;
    bus.sample_ready = 1'b0;
    cfg(24'h300000, MODE_SAW, 0, 255);
    run(6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", int'(bus.sample_valid), 0);
    chk("midrst_overrun", int'(bus.overrun), 0);
    chk("midrst_data", int'(bus.sample_data), 0);
    bus.sample_ready = 1'b1;
    bus.cfg_div = '0;
    cfg(24'h010000, MODE_SAW, 0, 8'h80);
    run(300);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
